// File: rtl/fine_cfo_nco.sv
// Fine-CFO phase accumulator followed by a pipelined rotation-mode CORDIC that
// converts each accepted phase token into a cos/sin pair for the CFO multiplier.
module fine_cfo_nco #(
  parameter int PHASE_W = 32,
  parameter int OUT_W   = 16,
  parameter int ITER    = 16
) (
  input  logic                       ap_clk,
  input  logic                       ap_rst_n,
  input  logic                       cfg_valid,
  input  logic [PHASE_W-1:0]         cfg_phase_inc,
  input  logic                       cfg_start,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [OUT_W-1:0]    out_cos,
  output logic signed [OUT_W-1:0]    out_sin,
  output logic                       out_last
);

  localparam int XW = OUT_W + 2;
  localparam longint FS  = (longint'(1) << (OUT_W - 1)) - 1;
  localparam longint X0L = (FS * 607252935 + 500000000) / 1000000000;
  localparam logic signed [XW-1:0] X0   = XW'(X0L);
  localparam logic signed [XW-1:0] MAXV = XW'(FS);
  localparam logic signed [XW-1:0] MINV = -MAXV;

  // round(atan(2^-i) * 2^32 / (2*pi)), rescaled to PHASE_W
  function automatic logic [PHASE_W-1:0] atan_const(input int i);
    logic [31:0] t;
    longint      v;
    int          sh;
    case (i)
      0:  t = 32'd536870912;
      1:  t = 32'd316933406;
      2:  t = 32'd167458907;
      3:  t = 32'd85004756;
      4:  t = 32'd42667331;
      5:  t = 32'd21354465;
      6:  t = 32'd10679838;
      7:  t = 32'd5340245;
      8:  t = 32'd2670163;
      9:  t = 32'd1335087;
      10: t = 32'd667544;
      11: t = 32'd333772;
      12: t = 32'd166886;
      13: t = 32'd83443;
      14: t = 32'd41722;
      15: t = 32'd20861;
      16: t = 32'd10430;
      17: t = 32'd5215;
      18: t = 32'd2608;
      19: t = 32'd1304;
      20: t = 32'd652;
      21: t = 32'd326;
      22: t = 32'd163;
      23: t = 32'd81;
      24: t = 32'd41;
      25: t = 32'd20;
      26: t = 32'd10;
      27: t = 32'd5;
      28: t = 32'd3;
      29: t = 32'd1;
      30: t = 32'd1;
      default: t = 32'd0;
    endcase
    v  = longint'(t);
    sh = 32 - PHASE_W;
    if (sh > 0)
      v = (v + (longint'(1) << (sh - 1))) >>> sh;
    else if (sh < 0)
      v = v << (-sh);
    return PHASE_W'(v);
  endfunction

  function automatic logic signed [OUT_W-1:0] sat(input logic signed [XW-1:0] v);
    if (v > MAXV)
      return OUT_W'(MAXV);
    else if (v < MINV)
      return OUT_W'(MINV);
    else
      return v[OUT_W-1:0];
  endfunction

  logic               en;
  logic               accept;
  logic               fold;
  logic [PHASE_W-1:0] acc;
  logic [PHASE_W-1:0] inc;
  logic [PHASE_W-1:0] phase;

  assign en       = ~out_valid | out_ready;
  assign in_ready = en;
  assign accept   = in_valid & en;
  assign phase    = cfg_start ? '0 : acc;
  assign fold     = phase[PHASE_W-1] ^ phase[PHASE_W-2];

  // Configuration is honoured regardless of pipeline stall.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      acc <= '0;
      inc <= '0;
    end else begin
      if (cfg_valid)
        inc <= cfg_phase_inc;
      if (cfg_start)
        acc <= accept ? (cfg_valid ? cfg_phase_inc : inc) : '0;
      else if (accept)
        acc <= acc + inc;
    end
  end

  // Index 0 is the fold stage; 1..ITER are the micro-rotations.
  logic signed [XW-1:0]  sx [0:ITER];
  logic signed [XW-1:0]  sy [0:ITER];
  logic [PHASE_W-1:0]    sz [0:ITER];
  logic                  sv [0:ITER];
  logic                  sn [0:ITER];
  logic                  sl [0:ITER];

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      for (int i = 0; i <= ITER; i++) begin
        sx[i] <= '0;
        sy[i] <= '0;
        sz[i] <= '0;
        sv[i] <= 1'b0;
        sn[i] <= 1'b0;
        sl[i] <= 1'b0;
      end
    end else if (en) begin
      // subtracting pi only flips the MSB of the phase word
      sx[0] <= X0;
      sy[0] <= '0;
      sz[0] <= {phase[PHASE_W-1] ^ fold, phase[PHASE_W-2:0]};
      sv[0] <= accept;
      sn[0] <= fold;
      sl[0] <= in_last;
      for (int i = 0; i < ITER; i++) begin
        sv[i+1] <= sv[i];
        sn[i+1] <= sn[i];
        sl[i+1] <= sl[i];
        if (!sz[i][PHASE_W-1]) begin
          sx[i+1] <= sx[i] - (sy[i] >>> i);
          sy[i+1] <= sy[i] + (sx[i] >>> i);
          sz[i+1] <= sz[i] - atan_const(i);
        end else begin
          sx[i+1] <= sx[i] + (sy[i] >>> i);
          sy[i+1] <= sy[i] - (sx[i] >>> i);
          sz[i+1] <= sz[i] + atan_const(i);
        end
      end
    end
  end

  logic signed [XW-1:0] x_fin;
  logic signed [XW-1:0] y_fin;

  always_comb begin
    x_fin = sn[ITER] ? -sx[ITER] : sx[ITER];
    y_fin = sn[ITER] ? -sy[ITER] : sy[ITER];
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      out_valid <= 1'b0;
      out_cos   <= '0;
      out_sin   <= '0;
      out_last  <= 1'b0;
    end else if (en) begin
      out_valid <= sv[ITER];
      out_cos   <= sat(x_fin);
      out_sin   <= sat(y_fin);
      out_last  <= sl[ITER];
    end
  end

endmodule

// File: tb/tb_fine_cfo_nco.sv
// Directed bench for fine_cfo_nco: scoreboard against an independent CORDIC
// model plus hand-derived expectations for latency, quadrant points and restarts.
module tb_fine_cfo_nco;

  localparam real PI = 3.141592653589793;

  logic               ap_clk = 1'b0;
  logic               ap_rst_n = 1'b0;
  logic               cfg_valid = 1'b0;
  logic [31:0]        cfg_phase_inc = '0;
  logic               cfg_start = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic               in_last = 1'b0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic signed [15:0] out_cos;
  logic signed [15:0] out_sin;
  logic               out_last;

  fine_cfo_nco dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .cfg_valid(cfg_valid), .cfg_phase_inc(cfg_phase_inc), .cfg_start(cfg_start),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_cos(out_cos), .out_sin(out_sin), .out_last(out_last)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct { int c; int s; logic l; } exp_t;
  exp_t        q[$];
  logic [31:0] atan_tab [16];
  logic [31:0] m_acc, m_inc;
  int          checks = 0;
  int          failures = 0;
  int          test_id = 0;
  int          n_out = 0;
  bit          acc_now;
  int          e2c [4] = '{32767, 0, -32767, 0};
  int          e2s [4] = '{0, 32767, 0, -32767};

  task automatic check(input string tag, input longint obs, input longint expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int sat16(input logic signed [17:0] v);
    if (v > 18'sd32767) return 32767;
    if (v < -18'sd32767) return -32767;
    return int'(v);
  endfunction

  function automatic void nco_model(input logic [31:0] p, output int c, output int s);
    logic signed [17:0] x, y, xs, ys;
    logic [31:0] z;
    logic neg;
    neg = p[31] ^ p[30];
    z   = neg ? p - 32'h8000_0000 : p;
    x   = 18'sd19898;
    y   = '0;
    for (int i = 0; i < 16; i++) begin
      xs = x >>> i;
      ys = y >>> i;
      if (!z[31]) begin x = x - ys; y = y + xs; z = z - atan_tab[i]; end
      else        begin x = x + ys; y = y - xs; z = z + atan_tab[i]; end
    end
    if (neg) begin x = -x; y = -y; end
    c = sat16(x);
    s = sat16(y);
  endfunction

  // Monitor/scoreboard: handshakes are evaluated mid-cycle, before the edge that commits them.
  initial forever begin
    exp_t e;
    int   c, s;
    logic [31:0] p;
    @(negedge ap_clk);
    if (!ap_rst_n) begin
      m_acc = '0;
      m_inc = '0;
      q.delete();
    end else begin
      if (out_valid && out_ready) begin
        check("sb_has_token", q.size() != 0, 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          check("sb_cos", out_cos, e.c);
          check("sb_sin", out_sin, e.s);
          check("sb_last", out_last, e.l);
        end
        if (test_id == 1 || (test_id == 6 && n_out == 0) || (test_id == 5 && n_out == 36)) begin
          check("near_zero_cos", (out_cos >= 32763 && out_cos <= 32767), 1);
          check("near_zero_sin", (out_sin >= -4 && out_sin <= 4), 1);
        end
        if (test_id == 2) begin
          check("t2_cos_quad", iabs(out_cos - e2c[n_out % 4]) <= 4, 1);
          check("t2_sin_quad", iabs(out_sin - e2s[n_out % 4]) <= 4, 1);
        end
        if (test_id == 5)
          check("t5_last_pos", out_last, n_out == 35);
        n_out++;
      end
      if (in_valid && in_ready) begin
        p = cfg_start ? 32'd0 : m_acc;
        nco_model(p, c, s);
        e.c = c; e.s = s; e.l = in_last;
        q.push_back(e);
      end
      if (cfg_start)
        m_acc = (in_valid && in_ready) ? (cfg_valid ? cfg_phase_inc : m_inc) : 32'd0;
      else if (in_valid && in_ready)
        m_acc = m_acc + m_inc;
      if (cfg_valid)
        m_inc = cfg_phase_inc;
    end
  end

  task automatic step();
    @(negedge ap_clk);
    acc_now = in_valid && in_ready;
    @(posedge ap_clk);
    #1;
  endtask

  task automatic configure(input logic [31:0] v);
    cfg_valid = 1'b1;
    cfg_phase_inc = v;
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int b = 0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    while ((q.size() != 0 || out_valid) && b < 400) begin
      step();
      b++;
    end
    check(tag, q.size(), 0);
  endtask

  task automatic send_tokens(input int n, input bit rnd);
    int sent = 0;
    int b = 0;
    in_valid = 1'b1;
    while (sent < n && b < 20000) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      in_last = ((sent % 100) == 99);
      step();
      b++;
      if (acc_now) sent++;
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    check("send_budget", sent, n);
  endtask

  initial begin
    int k, first, sent;
    for (int i = 0; i < 16; i++)
      atan_tab[i] = 32'($rtoi($floor($atan(2.0 ** (-i)) * 4294967296.0 / (2.0 * PI) + 0.5)));

    ap_rst_n = 1'b0;
    repeat (3) @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_cos", out_cos, 0);
    check("rst_out_sin", out_sin, 0);
    check("rst_out_last", out_last, 0);
    check("rst_in_ready", in_ready, 1);

    // 1: zero increment, latency
    test_id = 1; n_out = 0;
    in_valid = 1'b1; k = 0; first = 0; sent = 0;
    while (k < 60) begin
      step();
      k++;
      if (acc_now) sent++;
      if (sent == 8) in_valid = 1'b0;
      if (out_valid && first == 0) first = k;
    end
    check("t1_latency", first, 18);
    drain("t1_drain");
    check("t1_count", n_out, 8);

    // 2: quarter-turn increment
    test_id = 0;
    configure(32'h4000_0000);
    test_id = 2; n_out = 0;
    send_tokens(8, 1'b0);
    drain("t2_drain");
    check("t2_count", n_out, 8);

    // 3: long stream under random backpressure
    test_id = 0;
    configure(32'h0147_AE14);
    test_id = 3; n_out = 0;
    send_tokens(1000, 1'b1);
    drain("t3_drain");
    check("t3_count", n_out, 1000);

    // 4: sustained stall with input pending, cfg update during the stall
    test_id = 4; n_out = 0; sent = 0;
    configure(32'h0100_0000);
    in_valid = 1'b1; out_ready = 1'b1;
    for (int j = 0; j < 25; j++) begin
      in_last = ((sent % 7) == 6);
      step();
      if (acc_now) sent++;
    end
    out_ready = 1'b0;
    #1;
    for (int j = 0; j < 20; j++) begin
      check("t4_in_ready_low", in_ready, 0);
      check("t4_out_valid_held", out_valid, 1);
      if (q.size() != 0) begin
        check("t4_hold_cos", out_cos, q[0].c);
        check("t4_hold_sin", out_sin, q[0].s);
      end
      cfg_valid = (j == 10);
      cfg_phase_inc = 32'h0300_0000;
      step();
      cfg_valid = 1'b0;
      if (acc_now) sent++;
    end
    out_ready = 1'b1;
    for (int j = 0; j < 10; j++) begin
      in_last = ((sent % 7) == 6);
      step();
      if (acc_now) sent++;
    end
    in_last = 1'b0;
    drain("t4_drain");
    check("t4_count", n_out, sent);

    // 5: packet restart with accept, mid-stream increment change
    test_id = 0;
    configure(32'h0147_AE14);
    test_id = 5; n_out = 0; sent = 0;
    in_valid = 1'b1; out_ready = 1'b1;
    while (sent < 50 && k < 2000) begin
      in_last = (sent == 35);
      cfg_start = (sent == 36);
      cfg_valid = (sent == 20);
      cfg_phase_inc = 32'h0200_0000;
      step();
      k++;
      if (acc_now) sent++;
    end
    cfg_start = 1'b0; cfg_valid = 1'b0; in_last = 1'b0;
    drain("t5_drain");
    check("t5_count", n_out, 50);

    // 6: reset in the middle of a stream
    test_id = 0;
    configure(32'h0147_AE14);
    test_id = 6;
    in_valid = 1'b1; out_ready = 1'b1;
    repeat (25) step();
    check("t6_pre_valid", out_valid, 1);
    ap_rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    check("t6_rst_valid", out_valid, 0);
    check("t6_rst_cos", out_cos, 0);
    check("t6_rst_last", out_last, 0);
    repeat (3) @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b1;
    n_out = 0;
    send_tokens(3, 1'b0);
    drain("t6_drain");
    check("t6_count", n_out, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
